// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer for the 16-bit pipeline (req/ack data memory).
// Define MEM_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT_CYCLES.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mRead,
  input  logic        mWrite,
  input  logic        mByte,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        rdata_valid,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, RMW_RD, RMW_MERGE, RMW_WR, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] rdata_out_q, rdata_out_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        byte_q, byte_d;
  logic        lane_q, lane_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [15:0] rmw_q, rmw_d;
  logic        err_d;

  logic        req;
  logic        ack;
  logic [7:0]  rbyte;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q;
`endif

  assign req   = mRead | mWrite;
  assign ack   = mem_ack & mem_req_q;
  // lane 0 is the high byte of the word
  assign rbyte = lane_q ? mem_rdata[7:0] : mem_rdata[15:8];

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_out_d   = rdata_out_q;
    rdata_valid_d = 1'b0;
    byte_d        = byte_q;
    lane_d        = lane_q;
    wbyte_d       = wbyte_q;
    rmw_d         = rmw_q;
    err_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {addr[15:1], 1'b0};
          byte_d     = mByte;
          lane_d     = addr[0];
          wbyte_d    = wdata[7:0];
          if (mWrite && mByte) begin
            state_d  = RMW_RD;
            mem_we_d = 1'b0;
          end else if (mWrite) begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = wdata;
          end else begin
            state_d  = RD;
            mem_we_d = 1'b0;
          end
        end
      end
      RD: begin
        if (ack) begin
          rdata_out_d   = byte_q ? {{8{rbyte[7]}}, rbyte}
                                 : mem_rdata;
          rdata_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = DONE;
        end
      end
      WR, RMW_WR: begin
        if (ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end
      end
      RMW_RD: begin
        if (ack) begin
          rmw_d     = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RMW_MERGE;
        end
      end
      RMW_MERGE: begin
        mem_wdata_d = lane_q ? {rmw_q[15:8], wbyte_q}
                             : {wbyte_q, rmw_q[7:0]};
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        state_d     = RMW_WR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    if (mem_req_d && !mem_req_q) begin
      cnt_d = '0;
    end else if (mem_req_q && !mem_ack) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == TIMEOUT_CYCLES[7:0]) begin
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        rdata_valid_d = 1'b0;
        err_d         = 1'b1;
        state_d       = DONE;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_out_q   <= '0;
      rdata_valid_q <= 1'b0;
      byte_q        <= 1'b0;
      lane_q        <= 1'b0;
      wbyte_q       <= '0;
      rmw_q         <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_out_q   <= rdata_out_d;
      rdata_valid_q <= rdata_valid_d;
      byte_q        <= byte_d;
      lane_q        <= lane_d;
      wbyte_q       <= wbyte_d;
      rmw_q         <= rmw_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata_out   = rdata_out_q;
  assign rdata_valid = rdata_valid_q;
  assign stall       = (state_q == IDLE) ? req : (state_q != DONE);

`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
  logic unused_err;
  assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized self-checking bench for mem_stage_ctrl.
// A word-addressed memory model answers the handshake; expectations come from access rules.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mRead, mWrite, mByte;
  logic [15:0] addr, wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic        err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mRead(mRead), .mWrite(mWrite), .mByte(mByte),
    .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .err(err)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] last_rdata;

  int  o_stall, o_reads, o_writes, o_valid, o_err, o_gap, o_reqcyc;
  bit  o_to, o_addr_bad;
  logic [15:0] o_wdata, o_rdata;

  function automatic logic [15:0] mget(logic [15:0] wa);
    return mem.exists(wa) ? mem[wa] : (wa ^ 16'hC3A5);
  endfunction

  function automatic logic [15:0] exp_load(logic byt, logic [15:0] a);
    logic [15:0] w;
    logic [7:0]  b;
    w = mget({a[15:1], 1'b0});
    b = a[0] ? w[7:0] : w[15:8];
    return byt ? {{8{b[7]}}, b} : w;
  endfunction

  function automatic logic [15:0] exp_store(logic byt, logic [15:0] a,
                                            logic [15:0] wd);
    logic [15:0] w;
    w = mget({a[15:1], 1'b0});
    if (!byt) return wd;
    return a[0] ? {w[15:8], wd[7:0]} : {wd[7:0], w[7:0]};
  endfunction

  task automatic idle_inputs();
    mRead = 0; mWrite = 0; mByte = 0; addr = 0; wdata = 0;
  endtask

  // One access; dly = req-high cycle that gets the ack (0 = never ack).
  task automatic drive_op(input logic rd, input logic wr, input logic byt,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int dly, input bit scr, input bit noise);
    int   run;
    bit   done;
    logic req_now;
    logic [15:0] wa;
    run = 0; done = 0; wa = {a[15:1], 1'b0};
    o_stall = 0; o_reads = 0; o_writes = 0; o_valid = 0; o_err = 0;
    o_gap = 0; o_reqcyc = 0; o_to = 0; o_addr_bad = 0;
    o_wdata = 'x; o_rdata = 'x;
    @(negedge clk);
    mRead = rd; mWrite = wr; mByte = byt; addr = a; wdata = wd;
    mem_ack = 0;
    #1;
    if (stall) o_stall++;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (scr) begin
        mRead = 1'($urandom); mWrite = 1'($urandom);
        mByte = 1'($urandom); addr = 16'($urandom);
        wdata = 16'($urandom);
      end
      mem_ack = 0; mem_rdata = 16'($urandom);
      req_now = mem_req;
      if (req_now) begin
        run++; o_reqcyc++;
        if (mem_addr !== wa) o_addr_bad = 1;
        if (dly != 0 && run == dly) begin
          mem_ack = 1;
          if (mem_we) begin
            o_writes++; o_wdata = mem_wdata; mem[wa] = mem_wdata;
          end else begin
            o_reads++; mem_rdata = mget(wa);
          end
        end
      end else begin
        run = 0;
        if (noise) mem_ack = 1'($urandom);
      end
      #1;
      if (rdata_valid) o_valid++;
      if (err) o_err++;
      if (!stall) begin
        o_rdata = rdata_out; done = 1;
        break;
      end
      o_stall++;
      if (!req_now) o_gap++;
    end
    if (!done) o_to = 1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_req, mem_we, rdata_valid, err} !== 4'b0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rdata_out !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h rd=%h v=%b err=%b required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, rdata_out, rdata_valid, err);
    end
    mRead = 1; #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL reset_stall_req: stall=%b required 1", stall);
    end
    mRead = 0; #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL reset_stall_idle: stall=%b required 0", stall);
    end
    rst = 0;
    last_rdata = 16'h0;
  endtask

  task automatic test_word_load();
    mem[16'h0104] = 16'hBEEF;
    drive_op(1, 0, 0, 16'h0104, 16'h0, 3, 1, 0);
    tests++;
    if (o_to || o_addr_bad || o_reads != 1 || o_writes != 0) begin
      fails++;
      $display("FAIL word_load_bus: to=%0b addr_bad=%0b reads=%0d writes=%0d required 0/0/1/0",
               o_to, o_addr_bad, o_reads, o_writes);
    end
    tests++;
    if (o_stall != 4 || o_rdata !== 16'hBEEF || o_valid != 1) begin
      fails++;
      $display("FAIL word_load_result: stall=%0d rdata=%h valid=%0d required 4/BEEF/1",
               o_stall, o_rdata, o_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (rdata_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL word_load_after: valid=%b stall=%b req=%b required 0/0/0",
               rdata_valid, stall, mem_req);
    end
    last_rdata = 16'hBEEF;
  endtask

  task automatic test_byte_load();
    mem[16'h0010] = 16'h12F0;
    drive_op(1, 0, 1, 16'h0011, 16'h0, 2, 0, 0);
    tests++;
    if (o_addr_bad || o_rdata !== 16'hFFF0 || o_valid != 1) begin
      fails++;
      $display("FAIL byte_load_lo: addr_bad=%0b rdata=%h valid=%0d required 0/FFF0/1",
               o_addr_bad, o_rdata, o_valid);
    end
    drive_op(1, 0, 1, 16'h0010, 16'h0, 1, 0, 0);
    tests++;
    if (o_addr_bad || o_rdata !== 16'h0012 || o_valid != 1) begin
      fails++;
      $display("FAIL byte_load_hi: addr_bad=%0b rdata=%h valid=%0d required 0/0012/1",
               o_addr_bad, o_rdata, o_valid);
    end
    last_rdata = 16'h0012;
  endtask

  task automatic test_byte_store();
    mem[16'h0020] = 16'h3456;
    drive_op(0, 1, 1, 16'h0020, 16'h00AB, 2, 0, 0);
    tests++;
    if (o_reads != 1 || o_writes != 1 || o_wdata !== 16'hAB56 || o_gap != 1) begin
      fails++;
      $display("FAIL byte_store_rmw: reads=%0d writes=%0d wdata=%h gap=%0d required 1/1/AB56/1",
               o_reads, o_writes, o_wdata, o_gap);
    end
    tests++;
    if (o_valid != 0 || o_rdata !== last_rdata || o_stall != 6) begin
      fails++;
      $display("FAIL byte_store_side: valid=%0d rdata=%h stall=%0d required 0/%h/6",
               o_valid, o_rdata, o_stall, last_rdata);
    end
  endtask

  task automatic test_read_write_both();
    drive_op(1, 1, 0, 16'h0042, 16'h7777, 1, 0, 0);
    tests++;
    if (o_reads != 0 || o_writes != 1 || o_wdata !== 16'h7777 ||
        o_valid != 0 || o_rdata !== last_rdata) begin
      fails++;
      $display("FAIL rw_both: reads=%0d writes=%0d wdata=%h valid=%0d rdata=%h required 0/1/7777/0/%h",
               o_reads, o_writes, o_wdata, o_valid, o_rdata, last_rdata);
    end
  endtask

  task automatic test_reset_mid_rmw();
    bit seen;
    int writes;
    seen = 0; writes = 0;
    @(negedge clk);
    mWrite = 1; mByte = 1; addr = 16'h0030; wdata = 16'h0011; mem_ack = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    mem_ack = 1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 0;
    rst = 1; #1;
    tests++;
    if (!seen || mem_req !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL rst_merge: seen=%0b req=%b stall=%b required 1/0/1",
               seen, mem_req, stall);
    end
    idle_inputs(); #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL rst_merge_idle: stall=%b required 0", stall);
    end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (mem_req || stall) writes++;
    end
    tests++;
    if (writes != 0) begin
      fails++;
      $display("FAIL rst_merge_nowrite: busy_cycles=%0d required 0", writes);
    end
    // reset while a read request is outstanding
    @(negedge clk);
    mRead = 1; addr = 16'h0050;
    @(negedge clk);
    idle_inputs();
    #1 rst = 1; #1;
    tests++;
    if (mem_req !== 1'b0 || rdata_out !== 16'h0) begin
      fails++;
      $display("FAIL rst_read: req=%b rdata=%h required 0/0000", mem_req, rdata_out);
    end
    @(negedge clk);
    rst = 0;
    last_rdata = 16'h0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    drive_op(1, 0, 0, 16'h0060, 16'h0, 0, 0, 0);
    tests++;
    if (o_to || o_reqcyc != 4 || o_err != 1 || o_valid != 0 ||
        o_stall != 5 || o_rdata !== last_rdata) begin
      fails++;
      $display("FAIL timeout: to=%0b reqcyc=%0d err=%0d valid=%0d stall=%0d rdata=%h required 0/4/1/0/5/%h",
               o_to, o_reqcyc, o_err, o_valid, o_stall, o_rdata, last_rdata);
    end
  endtask
`endif

  task automatic test_random_back_to_back();
    logic rd, wr, byt;
    logic [15:0] a, wd, e_w, e_r;
    int dly, nacc, e_stall;
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      rd  = wr ? 1'($urandom) : 1'b1;
      byt = 1'($urandom);
      a   = 16'($urandom_range(0, 31));
      if (i % 5 == 0) a = 16'($urandom);
      wd  = 16'($urandom);
      dly = $urandom_range(1, 4);
      e_w = exp_store(byt, a, wd);
      e_r = wr ? last_rdata : exp_load(byt, a);
      nacc = (wr && byt) ? 2 : 1;
      e_stall = 1 + dly * nacc + ((wr && byt) ? 1 : 0);
      drive_op(rd, wr, byt, a, wd, dly, 1, 1);
      tests++;
      if (o_to || o_addr_bad || o_stall != e_stall || o_err != 0) begin
        fails++;
        $display("FAIL rand_seq[%0d]: to=%0b addr_bad=%0b stall=%0d err=%0d required 0/0/%0d/0",
                 i, o_to, o_addr_bad, o_stall, o_err, e_stall);
      end
      tests++;
      if (o_reads != ((!wr || byt) ? 1 : 0) || o_writes != (wr ? 1 : 0) ||
          (wr && o_wdata !== e_w)) begin
        fails++;
        $display("FAIL rand_bus[%0d]: reads=%0d writes=%0d wdata=%h required wdata %h",
                 i, o_reads, o_writes, o_wdata, e_w);
      end
      tests++;
      if (o_rdata !== e_r || o_valid != (wr ? 0 : 1)) begin
        fails++;
        $display("FAIL rand_load[%0d]: rdata=%h valid=%0d required %h/%0d",
                 i, o_rdata, o_valid, e_r, wr ? 0 : 1);
      end
      last_rdata = e_r;
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_read_write_both();
    test_reset_mid_rmw();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the memory stage of the 16-bit pipeline against a multi-cycle, req/ack data memory.
- Takes the registered EX/M control fields (mRead, mWrite, mByte), the address and the store data.
- Drives the memory handshake and stalls the pipeline until the access completes.
- Byte stores are done as read-modify-write; byte loads are sign-extended.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles mem_req may stay high without mem_ack (used only with MEM_TIMEOUT_EN); range 1..255.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous reset, active-high
- mRead  in  1  load request from EX/M buffer
- mWrite  in  1  store request from EX/M buffer
- mByte  in  1  1 = byte access, 0 = word access
- addr  in  16  byte address; addr[0] selects the byte
- wdata  in  16  store data; byte stores use wdata[7:0]
- mem_req  out  1  registered; memory request
- mem_we  out  1  registered; 1 = write
- mem_addr  out  16  registered; word address {addr[15:1],1'b0}
- mem_wdata  out  16  registered write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  16  read data, valid when mem_ack=1
- stall  out  1  combinational; freeze IF..EX/M buffers
- rdata_out  out  16  registered load result
- rdata_valid  out  1  one-cycle pulse: rdata_out updated
- err  out  1  one-cycle timeout pulse (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (async): state=IDLE; mem_req, mem_we=0; mem_addr, mem_wdata, rdata_out=0; rdata_valid, err=0.
- States: IDLE, RD, WR, RMW_RD, RMW_MERGE, RMW_WR, DONE.
- Byte lane: addr[0]=0 selects [15:8]; addr[0]=1 selects [7:0].
- IDLE, request sampling:
  - Request = mRead|mWrite. mWrite wins if both are set; the read is dropped.
  - On request: latch addr and wdata, set mem_req=1, mem_addr=word address.
  - Word load -> RD, mem_we=0.
  - Word store -> WR, mem_we=1, mem_wdata=wdata.
  - Byte store -> RMW_RD, mem_we=0.
  - Byte load -> RD.
- RD, on mem_ack:
  - Word: rdata_out=mem_rdata.
  - Byte: rdata_out = selected byte sign-extended to 16 bits.
  - mem_req=0; rdata_valid=1 next cycle; -> DONE.
- WR, on mem_ack: mem_req=0, mem_we=0; -> DONE.
- RMW_RD, on mem_ack: capture mem_rdata; mem_req=0; -> RMW_MERGE.
- RMW_MERGE (exactly one cycle, mem_req low):
  - mem_wdata = captured word with the selected byte replaced by latched wdata[7:0].
  - mem_req=1, mem_we=1; -> RMW_WR.
- RMW_WR, on mem_ack: mem_req=0, mem_we=0; -> DONE.
- DONE: one cycle, stall=0 so the pipeline advances; the request still on the inputs is ignored; -> IDLE.
- stall = (state==IDLE & request) | (state not in {IDLE, DONE}).
- Latency: request seen in cycle 0; mem_req high from cycle 1. Ack in cycle k gives DONE in cycle k+1. RMW needs two acks.
- mem_ack while mem_req=0 is ignored. mem_rdata is used only in the ack cycle.
- Input changes while not in IDLE are ignored; latched values are used.
- rdata_out holds its value until the next load completes. Stores never change it.
- Reset mid-access: immediate IDLE with mem_req=0. A partial RMW write is never issued. stall then follows the inputs combinationally.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro: an 8-bit counter clears on each mem_req rising edge and increments while mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYCLES: mem_req=0, mem_we=0, -> DONE with err=1 for that cycle.
  - rdata_out is unchanged and rdata_valid=0.
  - An RMW aborted in RMW_RD never issues its write.
- Without the macro: no counter; err is tied to 0; accesses wait indefinitely.

Test Plan:
- Word load, addr=0x0104, ack on 3rd req cycle with mem_rdata=0xBEEF -> mem_addr=0x0104, mem_we=0, stall high 4 cycles, rdata_out=0xBEEF, rdata_valid one pulse.
- Byte load, addr=0x0011, mem_rdata=0x12F0 -> mem_addr=0x0010, rdata_out=0xFFF0. Same with addr=0x0010 -> rdata_out=0x0012.
- Byte store, addr=0x0020, wdata=0x00AB, first ack mem_rdata=0x3456 -> one idle cycle of mem_req, then a write with mem_wdata=0xAB56, mem_we=1. Two acks total; rdata_out unchanged.
- mRead=mWrite=1, mByte=0, wdata=0x7777 -> single write of 0x7777, no read issued, no rdata_valid.
- rst asserted in RMW_MERGE -> mem_req=0 immediately, no write issued. After release with inputs idle, stall=0 and state=IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack a load -> mem_req drops after 4 high cycles, err pulses once, rdata_valid=0, stall falls in the DONE cycle.
